// File: rtl/klp32_pkg.sv
// klp32_pkg -- shared load/store definitions for the KLP32 data path.
//   F3_*       : RISC-V funct3 codes for load/store access size and sign
//   size_e     : decoded access width
//   f3_dec_t   : decoded funct3 (size, unsigned flag, legal flag)
//   decode_f3  : funct3 + store flag -> f3_dec_t
package klp32_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef struct packed {
      size_e size;
      logic  uns;
      logic  legal;
   } f3_dec_t;

   // Unsigned variants exist only for loads; SBU/SHU are not instructions.
   function automatic f3_dec_t decode_f3(input logic [2:0] f3, input logic is_store);
      f3_dec_t d;
      d.size  = SZ_W;
      d.uns   = 1'b0;
      d.legal = 1'b0;
      case (f3)
         F3_B:  begin d.size = SZ_B; d.legal = 1'b1; end
         F3_H:  begin d.size = SZ_H; d.legal = 1'b1; end
         F3_W:  begin d.size = SZ_W; d.legal = 1'b1; end
         F3_BU: begin d.size = SZ_B; d.uns = 1'b1; d.legal = !is_store; end
         F3_HU: begin d.size = SZ_H; d.uns = 1'b1; d.legal = !is_store; end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/data_memory_bank.sv
// data_memory_bank -- DEPTH_WORDS x 32 array, byte-enable synchronous write,
// registered read. Single index shared by read and write (one request port).
//   clk     : clock
//   we_i    : write enable
//   be_i    : byte enables, bit b covers wdata_i[8b+7:8b]
//   idx_i   : word index
//   wdata_i : write data (already lane-replicated)
//   re_i    : read enable; rdata_o only updates when set
//   rdata_o : word read at the last enabled edge
module data_memory_bank #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   input  logic             re_i,
   output logic [31:0]      rdata_o
);

   if (INIT_ZERO) begin : g_zero
      logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
      logic [31:0] rdata_q;

      always_ff @(posedge clk) begin
         for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         if (re_i) rdata_q <= mem_q[idx_i];
      end
      assign rdata_o = rdata_q;
   end else begin : g_raw
      logic [31:0] mem_q [DEPTH_WORDS];
      logic [31:0] rdata_q;

      always_ff @(posedge clk) begin
         for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         if (re_i) rdata_q <= mem_q[idx_i];
      end
      assign rdata_o = rdata_q;
   end

endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu -- byte-addressable data memory for the KLP32 MEM stage.
// Valid/ready request in, registered one-cycle response out with backpressure.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (req_ready = !resp_valid || resp_ready)
//   req_write           : 1 = store, 0 = load
//   req_funct3          : RISC-V access size/sign
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   resp_valid/ready    : response handshake
//   resp_rdata          : extended load data, 0 for stores and faults
//   resp_error          : fault (illegal size, misaligned, out of range)
module data_memory_lsu
   import klp32_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error
);

   localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int WIDX_W = ADDR_WIDTH - 2;

   f3_dec_t           dec;
   logic [WIDX_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              accept, misalign, out_of_range, err;
   logic              do_write, do_read;
   logic [3:0]        be;
   logic [31:0]       wdata_rep;
   logic [31:0]       bank_rdata;

   // Response register: handshake state plus what the extender needs to
   // reshape the bank's registered read word.
   logic       resp_valid_q, resp_valid_d;
   logic       resp_error_q, resp_error_d;
   logic       ld_ok_q, ld_ok_d;
   logic [1:0] lane_q, lane_d;
   size_e      size_q, size_d;
   logic       uns_q, uns_d;

   assign dec      = decode_f3(req_funct3, req_write);
   assign word_idx = req_addr[ADDR_WIDTH-1:2];
   assign lane     = req_addr[1:0];

   assign req_ready = !resp_valid_q || resp_ready;
   // Reset also blocks the write side effect of a request presented with it.
   assign accept    = req_valid && req_ready && !reset;

   assign misalign     = ((dec.size == SZ_H) && lane[0]) ||
                         ((dec.size == SZ_W) && (lane != 2'b00));
   // Compare the full index so aliasing above the array never looks legal.
   assign out_of_range = ({1'b0, word_idx} >= (WIDX_W+1)'(DEPTH_WORDS));
   assign err          = !dec.legal || misalign || out_of_range;

   assign do_write = accept &&  req_write && !err;
   assign do_read  = accept && !req_write && !err;

   always_comb begin
      be        = 4'b1111;
      wdata_rep = req_wdata;
      case (dec.size)
         SZ_B: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         SZ_H: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   data_memory_bank #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W),
      .INIT_ZERO  (INIT_ZERO)
   ) u_bank (
      .clk    (clk),
      .we_i   (do_write),
      .be_i   (be),
      .idx_i  (word_idx[IDX_W-1:0]),
      .wdata_i(wdata_rep),
      .re_i   (do_read),
      .rdata_o(bank_rdata)
   );

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_error_d = resp_error_q;
      ld_ok_d      = ld_ok_q;
      lane_d       = lane_q;
      size_d       = size_q;
      uns_d        = uns_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_error_d = err;
         ld_ok_d      = do_read;
         lane_d       = lane;
         size_d       = dec.size;
         uns_d        = dec.uns;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         ld_ok_q      <= 1'b0;
         lane_q       <= 2'b00;
         size_q       <= SZ_W;
         uns_q        <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         ld_ok_q      <= ld_ok_d;
         lane_q       <= lane_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
      end
   end

   // Extension works only from registered state, so no req_* -> resp_* path.
   // The bank read register only moves on an accepted load, so the word
   // (and the extended result) holds while the response is stalled.
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext;

   always_comb begin
      byte_sel = bank_rdata[{lane_q, 3'b000} +: 8];
      half_sel = bank_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_B:    ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ext = bank_rdata;
      endcase
   end

   assign resp_valid = resp_valid_q;
   assign resp_error = resp_error_q;
   assign resp_rdata = ld_ok_q ? ext : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   data_memory_lsu dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_error(resp_error)
   );

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
      string       name;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // One transaction with resp_ready=1: present, accept at the edge, check after it.
   task automatic txn(input vec_t v);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk({v.name, ".valid"}, {31'b0, resp_valid}, 32'd1);
      chk({v.name, ".rdata"}, resp_rdata, v.rd);
      chk({v.name, ".error"}, {31'b0, resp_error}, {31'b0, v.err});
   endtask

   task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
   endtask

   initial begin
      //            wr    f3      addr     wdata          rd             err
      vt.push_back('{1'b1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0,         1'b0, "sw10"});
      vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0,         32'h8000_00F0, 1'b0, "lw10"});
      vt.push_back('{1'b0, 3'b000, 32'h10, 32'h0,         32'hFFFF_FFF0, 1'b0, "lb10"});
      vt.push_back('{1'b0, 3'b100, 32'h10, 32'h0,         32'h0000_00F0, 1'b0, "lbu10"});
      vt.push_back('{1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_8000, 1'b0, "lh12"});
      vt.push_back('{1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_8000, 1'b0, "lhu12"});
      vt.push_back('{1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0,         1'b0, "sw20"});
      vt.push_back('{1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0,         1'b0, "sb21"});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0,         32'h1122_AB44, 1'b0, "lw20a"});
      vt.push_back('{1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0,         1'b0, "sh22"});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0,         32'hBEEF_AB44, 1'b0, "lw20b"});
      vt.push_back('{1'b0, 3'b010, 32'h22, 32'h0,         32'h0,         1'b1, "lw_mis"});
      vt.push_back('{1'b1, 3'b001, 32'h23, 32'h0000_1234, 32'h0,         1'b1, "sh_mis"});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0,         32'hBEEF_AB44, 1'b0, "lw20c"});
      vt.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,         1'b1, "lw_oor"});
      vt.push_back('{1'b0, 3'b011, 32'h0,  32'h0,         32'h0,         1'b1, "ld_f3_011"});
      vt.push_back('{1'b1, 3'b100, 32'h20, 32'h0000_0055, 32'h0,         1'b1, "st_f3_100"});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0,         32'hBEEF_AB44, 1'b0, "lw20d"});
      vt.push_back('{1'b0, 3'b000, 32'h23, 32'h0,         32'hFFFF_FFBE, 1'b0, "lb23"});
      vt.push_back('{1'b0, 3'b001, 32'h20, 32'h0,         32'hFFFF_AB44, 1'b0, "lh20"});
      vt.push_back('{1'b0, 3'b101, 32'h22, 32'h0,         32'h0000_BEEF, 1'b0, "lhu22"});
      vt.push_back('{1'b1, 3'b010, 32'hFFC, 32'h7777_0001, 32'h0,        1'b0, "sw_last"});
      vt.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0,        32'h7777_0001, 1'b0, "lw_last"});
      vt.push_back('{1'b1, 3'b010, 32'h30, 32'hAAAA_0001, 32'h0,         1'b0, "sw30"});
      vt.push_back('{1'b1, 3'b010, 32'h34, 32'hBBBB_0002, 32'h0,         1'b0, "sw34"});
      vt.push_back('{1'b1, 3'b010, 32'h38, 32'hCCCC_0003, 32'h0,         1'b0, "sw38"});
      vt.push_back('{1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0,         1'b0, "sw40"});

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst.valid", {31'b0, resp_valid}, 32'd0);
      chk("rst.rdata", resp_rdata, 32'h0);
      chk("rst.error", {31'b0, resp_error}, 32'd0);
      chk("rst.ready", {31'b0, req_ready}, 32'd1);

      foreach (vt[i]) txn(vt[i]);

      // Backpressure: three back-to-back LWs, consumer stalls two cycles.
      @(negedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      drive(1'b0, 3'b010, 32'h30, 32'h0);
      @(posedge clk); #1;
      chk("bp.first.valid", {31'b0, resp_valid}, 32'd1);
      chk("bp.first.rdata", resp_rdata, 32'hAAAA_0001);
      chk("bp.first.ready", {31'b0, req_ready}, 32'd0);
      req_addr = 32'h34;
      @(posedge clk); #1;
      chk("bp.stall1.rdata", resp_rdata, 32'hAAAA_0001);
      chk("bp.stall1.valid", {31'b0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      chk("bp.stall2.rdata", resp_rdata, 32'hAAAA_0001);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp.second.rdata", resp_rdata, 32'hBBBB_0002);
      chk("bp.second.valid", {31'b0, resp_valid}, 32'd1);
      req_addr = 32'h38;
      @(posedge clk); #1;
      chk("bp.third.rdata", resp_rdata, 32'hCCCC_0003);
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp.drain.valid", {31'b0, resp_valid}, 32'd0);
      chk("bp.drain.hold", resp_rdata, 32'hCCCC_0003);

      // Reset with a pending response and a store presented at the same time.
      @(negedge clk);
      resp_ready = 1'b0;
      drive(1'b0, 3'b010, 32'h40, 32'h0);
      @(posedge clk); #1;
      chk("rs.pend.valid", {31'b0, resp_valid}, 32'd1);
      chk("rs.pend.rdata", resp_rdata, 32'hCAFE_F00D);
      reset      = 1'b1;
      resp_ready = 1'b1;
      drive(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("rs.valid", {31'b0, resp_valid}, 32'd0);
      chk("rs.rdata", resp_rdata, 32'h0);
      reset     = 1'b0;
      req_valid = 1'b0;
      txn('{1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, "rs.lw40"});

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
